// File: rtl/transcr_ctrl.sv
// ---------------------------------------------------------------------------
// transcr_ctrl
//
// Ready/valid flow controller wrapped around the free-running, fixed-latency
// Cr skin-tone transform pipeline.  Accepted pixels are tracked by a tag
// shift register (valid + sof + eol) that mirrors the pipeline latency.  Each
// result lands in an output FIFO, and the input is credit-gated so that a
// result always has a FIFO slot waiting for it.
//
// Optional feature macro: TRANSCR_CTRL_STATS_EN
//   When defined, the block adds saturating stat_pix / stat_stall counters.
//
// Ports
//   clk, rst_n           clock (rising edge), async active-low reset
//   en                   1 = accept pixels, 0 = stop accepting and drain
//   in_valid/in_ready    input handshake
//   in_cr, in_y          input samples
//   in_sof, in_eol       input sideband
//   pipe_cr, pipe_y      samples to the pipeline (combinational copies)
//   pipe_transcr         pipeline result, PIPE_LAT edges after capture
//   out_valid/out_ready  output handshake (out_valid = FIFO non-empty)
//   out_data             head result
//   out_sof, out_eol     head sideband
//   busy                 state != IDLE
//   stat_pix, stat_stall (TRANSCR_CTRL_STATS_EN only) accepted pixels,
//                        cycles with out_valid & !out_ready
// ---------------------------------------------------------------------------
module transcr_ctrl #(
    parameter int unsigned PIPE_LAT   = 6,
    parameter int unsigned OUT_W      = 8,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_cr,
    input  logic [7:0]       in_y,
    input  logic             in_sof,
    input  logic             in_eol,
    output logic [7:0]       pipe_cr,
    output logic [7:0]       pipe_y,
    input  logic [OUT_W-1:0] pipe_transcr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_sof,
    output logic             out_eol,
`ifdef TRANSCR_CTRL_STATS_EN
    output logic [31:0]      stat_pix,
    output logic [31:0]      stat_stall,
`endif
    output logic             busy
);

    localparam int unsigned TD = PIPE_LAT + 1;            // tag register depth
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);  // holds 0..FIFO_DEPTH
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned EW = OUT_W + 2;               // {data, sof, eol}

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t          state;
    logic [2:0]      tag_sr [TD];    // {valid, sof, eol}
    logic [CW-1:0]   inflight;
    logic [CW-1:0]   fifo_count;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [EW-1:0]   mem [FIFO_DEPTH];
    logic [CW:0]     credit_used;
    logic            accept;
    logic            wr_en;
    logic            rd_en;

    assign pipe_cr = in_cr;
    assign pipe_y  = in_y;

    // Credit covers both FIFO occupancy and results still in the pipe, so a
    // tag leaving the shift register always finds a free FIFO slot.
    assign credit_used = {1'b0, inflight} + {1'b0, fifo_count};
    assign in_ready    = (state == RUN) && (credit_used < (CW + 1)'(FIFO_DEPTH));

    assign accept    = in_valid & in_ready;
    assign wr_en     = tag_sr[TD-1][2];
    assign out_valid = (fifo_count != '0);
    assign rd_en     = out_valid & out_ready;
    assign busy      = (state != IDLE);

    assign out_data = mem[rd_ptr][EW-1:2];
    assign out_sof  = mem[rd_ptr][1];
    assign out_eol  = mem[rd_ptr][0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            inflight   <= '0;
            fifo_count <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            for (int unsigned i = 0; i < TD; i++) begin
                tag_sr[i] <= '0;
            end
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            // Tag register shifts every cycle; a bubble enters as a zero tag.
            tag_sr[0] <= accept ? {1'b1, in_sof, in_eol} : 3'b000;
            for (int unsigned i = 1; i < TD; i++) begin
                tag_sr[i] <= tag_sr[i-1];
            end

            if (accept && !wr_en) begin
                inflight <= inflight + CW'(1);
            end else if (!accept && wr_en) begin
                inflight <= inflight - CW'(1);
            end

            if (wr_en && !rd_en) begin
                fifo_count <= fifo_count + CW'(1);
            end else if (!wr_en && rd_en) begin
                fifo_count <= fifo_count - CW'(1);
            end

            if (wr_en) begin
                mem[wr_ptr] <= {pipe_transcr, tag_sr[TD-1][1], tag_sr[TD-1][0]};
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end

            unique case (state)
                IDLE:    if (en) state <= RUN;
                RUN:     if (!en) state <= DRAIN;
                DRAIN: begin
                    if (en) begin
                        state <= RUN;
                    end else if (inflight == '0 && fifo_count == '0) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef TRANSCR_CTRL_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_pix   <= '0;
            stat_stall <= '0;
        end else if (state == IDLE && en) begin
            stat_pix   <= '0;
            stat_stall <= '0;
        end else begin
            if (accept && stat_pix != '1) begin
                stat_pix <= stat_pix + 32'd1;
            end
            if (out_valid && !out_ready && stat_stall != '1) begin
                stat_stall <= stat_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_transcr_ctrl.sv
module tb_transcr_ctrl;

    localparam int unsigned PIPE_LAT   = 6;
    localparam int unsigned OUT_W      = 8;
    localparam int unsigned FIFO_DEPTH = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_cr;
    logic [7:0]       in_y;
    logic             in_sof;
    logic             in_eol;
    logic [7:0]       pipe_cr;
    logic [7:0]       pipe_y;
    logic [OUT_W-1:0] pipe_transcr;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_sof;
    logic             out_eol;
    logic             busy;
`ifdef TRANSCR_CTRL_STATS_EN
    logic [31:0]      stat_pix;
    logic [31:0]      stat_stall;
`endif

    int nerr  = 0;
    int nchk  = 0;
    int nread = 0;
    int nacc  = 0;
    logic [9:0] q [$];   // expected {sof, eol, data}
    logic [7:0] seq = 8'd0;

    always #5 clk = ~clk;

    transcr_ctrl #(
        .PIPE_LAT  (PIPE_LAT),
        .OUT_W     (OUT_W),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_cr       (in_cr),
        .in_y        (in_y),
        .in_sof      (in_sof),
        .in_eol      (in_eol),
        .pipe_cr     (pipe_cr),
        .pipe_y      (pipe_y),
        .pipe_transcr(pipe_transcr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_sof     (out_sof),
        .out_eol     (out_eol),
`ifdef TRANSCR_CTRL_STATS_EN
        .stat_pix    (stat_pix),
        .stat_stall  (stat_stall),
`endif
        .busy        (busy)
    );

    // Stand-in transform; the pipeline model captures at edge k and presents
    // the result after edge k+PIPE_LAT (no reset, like the real pipe).
    function automatic logic [7:0] xf(input logic [7:0] cr, input logic [7:0] y);
        return (cr + {1'b0, y[7:1]}) ^ 8'h5A;
    endfunction

    logic [7:0] pipe_r [PIPE_LAT+1];
    always @(posedge clk) begin
        pipe_r[0] <= xf(pipe_cr, pipe_y);
        for (int i = 1; i <= int'(PIPE_LAT); i++) pipe_r[i] <= pipe_r[i-1];
    end
    assign pipe_transcr = pipe_r[PIPE_LAT];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample handshakes mid-cycle, then advance to 1 time unit
    // past the rising edge.
    task automatic tick();
        logic [9:0] e;
        @(negedge clk);
        if (out_valid && out_ready) begin
            nread++;
            chk("read_nonempty", 32'(q.size() > 0), 32'd1);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("out_entry", {22'd0, out_sof, out_eol, out_data}, {22'd0, e});
            end
        end
        if (in_valid && in_ready) begin
            nacc++;
            q.push_back({in_sof, in_eol, xf(in_cr, in_y)});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive_pix(input logic sof, input logic eol);
        in_valid = 1'b1;
        in_cr    = seq * 8'd7 + 8'd3;
        in_y     = 8'd200 - seq;
        in_sof   = sof;
        in_eol   = eol;
        seq      = seq + 8'd1;
    endtask

    task automatic drain(input int maxc);
        for (int n = 0; n < maxc && q.size() != 0; n++) tick();
        chk("drain_empty", 32'(q.size()), 32'd0);
    endtask

    initial begin
        int base;
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst_n = 1'b0; en = 1'b0; in_valid = 1'b0; in_cr = '0; in_y = '0;
        in_sof = 1'b0; in_eol = 1'b0; out_ready = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_out", {22'd0, out_sof, out_eol, out_data}, 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        chk("idle_in_ready", 32'(in_ready), 32'd0);

        // Single pixel latency
        en = 1'b1;
        tick();
        chk("run_in_ready", 32'(in_ready), 32'd1);
        chk("run_busy", 32'(busy), 32'd1);
        in_valid = 1'b1; in_cr = 8'h90; in_y = 8'h80; in_sof = 1'b1; in_eol = 1'b0;
        tick();                                   // edge k
        in_valid = 1'b0; in_sof = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            chk("lat_not_yet", 32'(out_valid), 32'd0);
        end
        tick();                                   // edge k+7
        chk("lat_valid", 32'(out_valid), 32'd1);
        chk("lat_sof", 32'(out_sof), 32'd1);
        chk("lat_data", 32'(out_data), 32'(xf(8'h90, 8'h80)));
        chk("lat_busy", 32'(busy), 32'd1);
        out_ready = 1'b1;
        tick();
        chk("lat_read_empty", 32'(out_valid), 32'd0);

        // 100 back-to-back pixels
        base = nread;
        for (int i = 0; i < 100; i++) begin
            drive_pix(i == 0, (i % 10) == 9);
            chk("stream_in_ready", 32'(in_ready), 32'd1);
            tick();
        end
        in_valid = 1'b0;
        drain(40);
        chk("stream_count", 32'(nread - base), 32'd100);
        tick(); tick();

        // Back-pressure: credit limits acceptance to FIFO_DEPTH
        base = nacc;
        out_ready = 1'b0;
        for (int i = 0; i < 40; i++) begin
            drive_pix(1'b0, (i % 4) == 3);
            tick();
        end
        chk("bp_accepted", 32'(nacc - base), 32'd16);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        out_ready = 1'b1;
        base = nread;
        for (int n = 0; n < 40 && out_valid; n++) tick();
        chk("bp_held", 32'(nread - base), 32'd16);
        for (int i = 0; i < 20; i++) begin
            drive_pix(1'b0, 1'b0);
            tick();
        end
        in_valid = 1'b0;
        drain(40);
        tick(); tick();

        // Drop en with 5 pixels in flight
        base = nread;
        for (int i = 0; i < 5; i++) begin
            drive_pix(i == 0, i == 4);
            if (i == 4) en = 1'b0;
            tick();
        end
        chk("drain_in_ready", 32'(in_ready), 32'd0);
        for (int n = 0; n < 30 && (nread - base) < 5; n++) tick();
        chk("drain_count", 32'(nread - base), 32'd5);
        chk("drain_busy_hi", 32'(busy), 32'd1);
        tick();
        chk("drain_busy_lo", 32'(busy), 32'd0);
        chk("drain_q", 32'(q.size()), 32'd0);
        in_valid = 1'b0;

        // Reset mid-stream with FIFO half full
        en = 1'b1;
        out_ready = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) begin
            drive_pix(1'b0, 1'b0);
            tick();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("mid_out_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        q.delete();
        tick(); tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        base = nread;
        for (int i = 0; i < 15; i++) tick();
        chk("mid_no_stale", 32'(nread - base), 32'd0);
        for (int i = 0; i < 3; i++) begin
            drive_pix(1'b0, 1'b1);
            tick();
        end
        in_valid = 1'b0;
        drain(30);

`ifdef TRANSCR_CTRL_STATS_EN
        en = 1'b0;
        for (int n = 0; n < 20 && busy; n++) tick();
        chk("st_idle", 32'(busy), 32'd0);
        en = 1'b1;
        tick();
        chk("st_pix_clr0", stat_pix, 32'd0);
        chk("st_stall_clr0", stat_stall, 32'd0);
        for (int i = 0; i < 20; i++) begin
            drive_pix(1'b0, 1'b0);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            chk("st_stall_valid", 32'(out_valid), 32'd1);
            tick();
        end
        out_ready = 1'b1;
        drain(40);
        chk("st_pix", stat_pix, 32'd20);
        chk("st_stall", stat_stall, 32'd7);
        en = 1'b0;
        for (int n = 0; n < 20 && busy; n++) tick();
        en = 1'b1;
        tick();
        chk("st_pix_clr", stat_pix, 32'd0);
        chk("st_stall_clr", stat_stall, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
